// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges execute and load results onto the register file write port
//
// Execute beats (primary rd plus optional base-register writeback) are queued in a small
// compacting FIFO. Load results bypass the FIFO, take priority on the single write port and
// cancel any queued write to the same register. A per-register pending mask lets decode stall
// on writes that are still queued.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid / ex_ready      execute beat handshake
//   ex_rd_en, ex_rd, ex_rd_data      primary write carried by the beat
//   ex_wb_en, ex_wb_reg, ex_wb_data  base-register writeback carried by the beat
//   mem_valid, mem_rd, mem_data      load result, never backpressured
//   write, write_req, write_data     registered register file write port
//   pending                  bit r set while a queued entry targets register r
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_rd_en,
  input  logic [3:0]  ex_rd,
  input  logic [31:0] ex_rd_data,
  input  logic        ex_wb_en,
  input  logic [3:0]  ex_wb_reg,
  input  logic [31:0] ex_wb_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic [3:0]  write,
  output logic        write_req,
  output logic [31:0] write_data,
  output logic [15:0] pending
);

  localparam int NCAND = DEPTH + 2;

  // Queue storage. Valid entries are always packed at the low slots (slot 0 is the head),
  // so q_vld is a thermometer code and occupancy never needs an explicit counter.
  logic [3:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;

  logic accept;
  logic push_rd;
  logic push_wb;
  logic pop;

  // Candidates for the next queue contents: current entries followed by this cycle's pushes.
  logic [3:0]       c_reg  [NCAND];
  logic [31:0]      c_data [NCAND];
  logic [NCAND-1:0] c_keep;

  logic [3:0]       n_reg  [DEPTH];
  logic [31:0]      n_data [DEPTH];
  logic [DEPTH-1:0] n_vld;
  logic [15:0]      n_pending;

  // Two free slots are always required so a dual-write beat can never overflow; the
  // decision depends on occupancy only, never on ex_valid.
  assign ex_ready = !rst && !q_vld[DEPTH-2];
  assign accept   = ex_valid && ex_ready;
  assign push_rd  = accept && ex_rd_en;
  // Writing the same register twice from one beat: the primary result is the one that counts.
  assign push_wb  = accept && ex_wb_en && !(ex_rd_en && (ex_rd == ex_wb_reg));
  // A load owns the port this cycle, so the queue only drains when no load is present.
  assign pop      = !mem_valid && q_vld[0];

  always_comb begin
    int pos;
    for (int k = 0; k < DEPTH; k++) begin
      c_reg[k]  = q_reg[k];
      c_data[k] = q_data[k];
      // The load is architecturally younger than anything queued, so a queued write to the
      // same register is dead and is dropped here rather than reaching the port.
      c_keep[k] = q_vld[k] && !(pop && (k == 0)) && !(mem_valid && (q_reg[k] == mem_rd));
    end
    c_reg[DEPTH]    = ex_rd;
    c_data[DEPTH]   = ex_rd_data;
    c_keep[DEPTH]   = push_rd;
    c_reg[DEPTH+1]  = ex_wb_reg;
    c_data[DEPTH+1] = ex_wb_data;
    c_keep[DEPTH+1] = push_wb;

    for (int j = 0; j < DEPTH; j++) begin
      n_reg[j]  = '0;
      n_data[j] = '0;
    end
    n_vld     = '0;
    n_pending = '0;

    // Compact the surviving candidates, preserving order, into the low slots.
    pos = 0;
    for (int k = 0; k < NCAND; k++) begin
      if (c_keep[k]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (pos == j) begin
            n_reg[j]  = c_reg[k];
            n_data[j] = c_data[k];
          end
        end
        pos = pos + 1;
      end
    end

    for (int j = 0; j < DEPTH; j++) begin
      n_vld[j] = (j < pos);
      if (j < pos) begin
        n_pending = n_pending | (16'd1 << n_reg[j]);
      end
    end
  end

  // Entry payloads need no reset; q_vld masks them.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      q_reg[j]  <= n_reg[j];
      q_data[j] <= n_data[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld      <= '0;
      pending    <= '0;
      write_req  <= 1'b0;
      write      <= '0;
      write_data <= '0;
    end else begin
      q_vld   <= n_vld;
      pending <= n_pending;
      if (mem_valid) begin
        write      <= mem_rd;
        write_data <= mem_data;
        write_req  <= 1'b1;
      end else if (q_vld[0]) begin
        write      <= q_reg[0];
        write_data <= q_data[0];
        write_req  <= 1'b1;
      end else begin
        // Index and data hold their last value; only the request drops.
        write_req <= 1'b0;
      end
    end
  end

endmodule
